// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with press/release debounce feeding a two-digit
// shift display (new key enters on the right, previous right digit moves left).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | rotate the low column, look for a single low row
// PRESS_DB | column frozen, waiting for the latched row to stay stable
// HELD     | key accepted, waiting for all rows to go high
// REL_DB   | all rows high, waiting for the release to stay stable
module keypad_scan_ctrl #(
  parameter int SCAN_COUNT     = 2400,
  parameter int DEBOUNCE_COUNT = 120000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] digit_left,
  output logic [3:0] digit_right,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int SW = $clog2(SCAN_COUNT);
  localparam int DW = (DEBOUNCE_COUNT > 2) ? $clog2(DEBOUNCE_COUNT) : 1;

  localparam logic [SW-1:0] SCAN_LAST   = SW'(SCAN_COUNT - 1);
  localparam logic [SW-1:0] SCAN_SETTLE = SW'(3);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_COUNT - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    rows_meta_q, rows_meta_d;
  logic [3:0]    rows_s_q, rows_s_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    row_lat_q, row_lat_d;
  logic [3:0]    digit_left_q, digit_left_d;
  logic [3:0]    digit_right_q, digit_right_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;

  logic [3:0]    key_decoded;

  function automatic logic single_low(input logic [3:0] pat);
    return (pat == 4'b1110) || (pat == 4'b1101) ||
           (pat == 4'b1011) || (pat == 4'b0111);
  endfunction

  function automatic logic [3:0] decode_key(input logic [3:0] row_pat,
                                            input logic [1:0] col);
    logic [1:0] r;
    logic [3:0] code;
    r = 2'd0;
    case (row_pat)
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    case ({r, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign key_decoded = decode_key(row_lat_q, col_idx_q);

  always_comb begin
    state_d       = state_q;
    rows_meta_d   = rows;
    rows_s_d      = rows_meta_q;
    scan_cnt_d    = scan_cnt_q;
    db_cnt_d      = db_cnt_q;
    col_idx_d     = col_idx_q;
    row_lat_d     = row_lat_q;
    digit_left_d  = digit_left_q;
    digit_right_d = digit_right_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;

    case (state_q)
      SCAN: begin
        // The first cycles of a column see stale rows through the synchronizer
        if (scan_cnt_q >= SCAN_SETTLE && single_low(rows_s_q)) begin
          row_lat_d = rows_s_q;
          db_cnt_d  = '0;
          state_d   = PRESS_DB;
        end else if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          col_idx_d  = col_idx_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      PRESS_DB: begin
        if (rows_s_q == row_lat_q) begin
          if (db_cnt_q == DB_LAST) begin
            digit_left_d  = digit_right_q;
            digit_right_d = key_decoded;
            key_code_d    = key_decoded;
            key_valid_d   = 1'b1;
            state_d       = HELD;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end else begin
          scan_cnt_d = '0;
          state_d    = SCAN;
        end
      end

      HELD: begin
        if (rows_s_q == 4'b1111) begin
          db_cnt_d = '0;
          state_d  = REL_DB;
        end
      end

      REL_DB: begin
        if (rows_s_q == 4'b1111) begin
          if (db_cnt_q == DB_LAST) begin
            scan_cnt_d = '0;
            col_idx_d  = col_idx_q + 2'd1;
            state_d    = SCAN;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end else begin
          state_d = HELD;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= SCAN;
      rows_meta_q   <= 4'b1111;
      rows_s_q      <= 4'b1111;
      scan_cnt_q    <= '0;
      db_cnt_q      <= '0;
      col_idx_q     <= 2'd0;
      row_lat_q     <= 4'b1111;
      digit_left_q  <= 4'h0;
      digit_right_q <= 4'h0;
      key_code_q    <= 4'h0;
      key_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rows_meta_q   <= rows_meta_d;
      rows_s_q      <= rows_s_d;
      scan_cnt_q    <= scan_cnt_d;
      db_cnt_q      <= db_cnt_d;
      col_idx_q     <= col_idx_d;
      row_lat_q     <= row_lat_d;
      digit_left_q  <= digit_left_d;
      digit_right_q <= digit_right_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
    end
  end

  assign cols        = ~(4'b0001 << col_idx_q);
  assign digit_left  = digit_left_q;
  assign digit_right = digit_right_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scans a 4x4 matrix keypad, debounces key press and release, and sequences the two digits shown on the dual seven-segment display. A newly accepted key shifts the old right digit to the left and places the new key on the right. Outputs feed the display time-multiplexer as its two 4-bit digit inputs. One key is registered per press, with no auto-repeat.

Parameters:
SCAN_COUNT, 2_400, cycles each column is driven during scanning; minimum 8.
DEBOUNCE_COUNT, 120_000, consecutive stable cycles required to accept a press or a release; minimum 2.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
rows  input  4  keypad row lines; active-low, externally pulled up; asynchronous
cols  output  4  keypad column drive; one-hot-low (exactly one bit 0)
digit_left  output  4  older digit, to the display multiplexer left position
digit_right  output  4  newest digit, to the display multiplexer right position
key_valid  output  1  one-cycle pulse when a key is accepted
key_code  output  4  code of the last accepted key; holds its value between pulses

Behaviour:
- Reset is clk and reset: synchronous, active-low.
- On reset, every output and internal state clears:
  - cols=4'b1110, digit_left=0, digit_right=0, key_code=0, key_valid=0
  - state=SCAN, column index=0, all counters=0, synchronizer flops=4'b1111.
- rows pass through a 2-flop synchronizer. rows_s in this section means the synchronized value.
- Column pattern by index: 0->1110, 1->1101, 2->1011, 3->0111. The index wraps 3->0.
- Valid pattern: rows_s has exactly one bit 0. 1111 is idle. Patterns with two or more zeros are invalid.
- Key map, row r = rows bit r, col c = index:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- State SCAN:
  - scan counter increments each cycle. At SCAN_COUNT-1 it goes to 0 and the column index advances.
  - rows_s is ignored while scan counter < 3 (column settle plus synchronizer).
  - With scan counter >= 3 and a valid pattern: latch row pattern and column index, clear debounce counter, go to PRESS_DB. The column freezes.
  - Invalid patterns are ignored and scanning continues.
- State PRESS_DB:
  - When rows_s equals the latched pattern: increment the debounce counter.
  - On the cycle the counter equals DEBOUNCE_COUNT-1 with a match, the next edge does all of:
    - digit_left<=digit_right, digit_right<=decoded key, key_code<=decoded key
    - key_valid=1 for exactly that cycle
    - state<=HELD.
  - Any mismatch (bounce, release, or another row): return to SCAN on the same column with the scan counter cleared. Digits are unchanged.
- State HELD:
  - Column stays frozen. Other keys and other rows are ignored.
  - When rows_s == 1111: clear the debounce counter and go to REL_DB.
  - No repeat, however long the key is held.
- State REL_DB:
  - rows_s == 1111 for DEBOUNCE_COUNT consecutive cycles: go to SCAN, advance the column index, clear the scan counter.
  - Any row low: return to HELD. This covers release bounce and does not register a new key.
- key_valid is 0 in every cycle except the acceptance cycle.
- Reset in any state takes priority and forces the reset values. A press in progress is discarded.
- Worst-case latency from a stable press to key_valid: 4*SCAN_COUNT + DEBOUNCE_COUNT + 3 cycles.

Test Plan:
All scenarios run with SCAN_COUNT=8, DEBOUNCE_COUNT=16; keypad model shorts col to row.
1. Assert reset low for 3 cycles -> cols=1110, digits 0/0, key_valid=0. Release reset -> cols rotates 1110,1101,1011,0111,1110, 8 cycles each.
2. Hold key '5' (r1,c1) for 100 cycles -> exactly one key_valid pulse, digit_right=5, digit_left=0, key_code=5. Release and idle 40 cycles -> no further pulse; scanning resumes.
3. Press '3' and release, then press 'A' and release -> digit_left=3, digit_right=A. Then press '0' -> left=A, right=0.
4. Press '7' for 10 cycles and release (shorter than debounce) -> no key_valid, digits unchanged, scanning resumes.
5. Accept '9', then bounce the release (high 5 cycles, low 3, then high), and press '1' while '9' is still held -> single pulse for 9 only. After a clean release, '1' is accepted -> left=9, right=1.
6. Assert reset while in HELD with digits 4/2 -> digits 0/0, key_valid=0, cols=1110 next cycle. The key still held after reset is accepted once after debounce.
